// File: rtl/sd_cmd_scheduler.sv
// SD host command scheduler: arbitrates host and auto-CMD12 requests, sequences the
// command engine and times out missing responses. Define SD_AUTO_CMD12_EN to enable CMD12.
module sd_cmd_scheduler #(
    parameter int unsigned TimeoutTicks = 64
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        sd_clk_tick_i,
    input  logic        host_valid_i,
    output logic        host_ready_o,
    input  logic [5:0]  host_index_i,
    input  logic [31:0] host_arg_i,
    input  logic [1:0]  host_rsp_type_i,
    input  logic        cmd12_req_i,
    output logic        cmd12_gnt_o,
    input  logic        abort_i,
    output logic        cmd_start_o,
    output logic [5:0]  cmd_index_o,
    output logic [31:0] cmd_arg_o,
    output logic [1:0]  rsp_type_o,
    input  logic        cmd_done_i,
    input  logic        rsp_done_i,
    output logic        inhibit_cmd_o,
    output logic        complete_o,
    output logic        complete_src_o,
    output logic        timeout_o
);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_TX, WAIT_RSP, DONE} state_e;

    localparam logic [9:0] TimeoutLimit = 10'(TimeoutTicks);

    state_e      state_q;
    logic [9:0]  cnt_q;
    logic [5:0]  index_q;
    logic [31:0] arg_q;
    logic [1:0]  rsp_q;
    logic        src_q;
    logic        start_q;
    logic        complete_q;
    logic        timeout_q;
    logic        accept_ok;

    // Requests are only visible in IDLE, out of reset and without a concurrent abort.
    assign accept_ok = rst_ni && (state_q == IDLE) && !abort_i;

`ifdef SD_AUTO_CMD12_EN
    assign cmd12_gnt_o    = accept_ok && cmd12_req_i;
    assign host_ready_o   = accept_ok && host_valid_i && !cmd12_req_i;
    assign complete_src_o = src_q;
`else
    logic unused_cmd12;
    assign unused_cmd12   = cmd12_req_i ^ src_q;
    assign cmd12_gnt_o    = 1'b0;
    assign host_ready_o   = accept_ok && host_valid_i;
    assign complete_src_o = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            index_q    <= '0;
            arg_q      <= '0;
            rsp_q      <= '0;
            src_q      <= 1'b0;
            start_q    <= 1'b0;
            complete_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            start_q    <= 1'b0;
            complete_q <= 1'b0;
            timeout_q  <= 1'b0;
            if (abort_i) begin
                state_q <= IDLE;
                cnt_q   <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (cmd12_gnt_o) begin
                            index_q <= 6'd12;
                            arg_q   <= '0;
                            rsp_q   <= 2'b11;
                            src_q   <= 1'b1;
                            start_q <= 1'b1;
                            state_q <= ISSUE;
                        end else if (host_ready_o) begin
                            index_q <= host_index_i;
                            arg_q   <= host_arg_i;
                            rsp_q   <= host_rsp_type_i;
                            src_q   <= 1'b0;
                            start_q <= 1'b1;
                            state_q <= ISSUE;
                        end
                    end
                    ISSUE: state_q <= WAIT_TX;
                    WAIT_TX: begin
                        if (cmd_done_i) begin
                            cnt_q <= '0;
                            if (rsp_q == 2'b00) begin
                                complete_q <= 1'b1;
                                state_q    <= DONE;
                            end else begin
                                state_q <= WAIT_RSP;
                            end
                        end
                    end
                    WAIT_RSP: begin
                        // A response arriving with the final tick beats the timeout;
                        // the timeout pulse occupies one cycle ahead of DONE.
                        if (rsp_done_i || timeout_q) begin
                            complete_q <= 1'b1;
                            state_q    <= DONE;
                        end else if (sd_clk_tick_i) begin
                            cnt_q <= cnt_q + 10'd1;
                            if ((cnt_q + 10'd1) == TimeoutLimit) begin
                                timeout_q <= 1'b1;
                            end
                        end
                    end
                    DONE:    state_q <= IDLE;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign cmd_start_o   = start_q;
    assign cmd_index_o   = index_q;
    assign cmd_arg_o     = arg_q;
    assign rsp_type_o    = rsp_q;
    assign complete_o    = complete_q;
    assign timeout_o     = timeout_q;
    assign inhibit_cmd_o = (state_q != IDLE);

endmodule
